bcd_conv_arbiter: RTL and testbench

BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

---
 rtl/bcd_conv_arbiter_pkg.sv | 18 +
 rtl/binary_to_BCD.sv | 62 ++++++
 rtl/bcd_conv_arbiter.sv | 146 ++++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared constants and FSM encoding for the arbitrated binary-to-BCD converter.
package bcd_conv_arbiter_pkg;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned OPER_W      = 14;
  localparam int unsigned BCD_W       = 16;
  localparam int unsigned BCD_MAX     = 9999;
  localparam int unsigned WDOG_CYC    = 31;
  localparam int unsigned RSP_LATENCY = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/binary_to_BCD.sv
// Sequential double-dabble converter: one bit per cycle after start, done_tick
// pulses 15 cycles after the start cycle with the 4-digit result on bcd_o.
module binary_to_BCD
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int unsigned BIN_W = OPER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_tick_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned SH_W  = BCD_W + BIN_W;

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             done_q;

  // Add-3 correction on every digit that would overflow after the shift.
  always_comb begin
    adj = bcd_q;
    for (int d = 0; d < 4; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bin_q <= bin_i;
        bcd_q <= '0;
        cnt_q <= CNT_W'(BIN_W);
        run_q <= 1'b1;
      end else if (run_q) begin
        {bcd_q, bin_q} <= SH_W'({adj, bin_q, 1'b0});
        cnt_q          <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_tick_o = done_q;
  assign bcd_o       = bcd_q;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter among requesters,
// with operand clamping, a completion watchdog and a one-cycle response strobe.
module bcd_conv_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = NUM_REQ,
  parameter int unsigned BIN_W = OPER_W,
  parameter int unsigned WDOG  = WDOG_CYC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*BIN_W-1:0]   req_bin,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [BCD_W-1:0]         rsp_bcd,
  output logic                     rsp_ovf,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam int unsigned WD_W = $clog2(WDOG + 1);

  state_t           state_q;
  logic [ID_W-1:0]  last_k_q;
  logic [ID_W-1:0]  id_q;
  logic [BIN_W-1:0] oper_q;
  logic             ovf_q;
  logic [WD_W-1:0]  wd_q;
  logic             busy_q;

  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [BCD_W-1:0] rsp_bcd_q;
  logic             rsp_ovf_q;
  logic             rsp_err_q;

  logic             win_vld;
  logic [ID_W-1:0]  win_k;
  logic [ID_W-1:0]  cand;
  logic [BIN_W-1:0] sel_bin;
  logic             conv_start_c;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;

  // Highest priority goes to the requester just after the last winner.
  always_comb begin
    win_vld = 1'b0;
    win_k   = '0;
    cand    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = last_k_q + ID_W'(i);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_k   = cand;
      end
    end
  end

  assign sel_bin      = req_bin[int'(win_k)*BIN_W +: BIN_W];
  assign gnt          = (state_q == ST_IDLE && win_vld && !reset) ? (N_REQ'(1'b1) << win_k) : '0;
  assign conv_start_c = (state_q == ST_LAUNCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_k_q    <= ID_W'(N_REQ - 1);
      id_q        <= '0;
      oper_q      <= '0;
      ovf_q       <= 1'b0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_bcd_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            last_k_q <= win_k;
            id_q     <= win_k;
            busy_q   <= 1'b1;
            state_q  <= ST_LAUNCH;
            if (sel_bin > BIN_W'(BCD_MAX)) begin
              oper_q <= BIN_W'(BCD_MAX);
              ovf_q  <= 1'b1;
            end else begin
              oper_q <= sel_bin;
              ovf_q  <= 1'b0;
            end
          end
        end
        ST_LAUNCH: begin
          wd_q    <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (conv_done) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_bcd_q   <= conv_bcd;
            rsp_ovf_q   <= ovf_q;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_RESP;
          end else if (wd_q == WD_W'(WDOG)) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_bcd_q   <= '0;
            rsp_ovf_q   <= ovf_q;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  binary_to_BCD #(.BIN_W(BIN_W)) u_conv (
    .clk         (clk),
    .reset       (reset),
    .start_i     (conv_start_c),
    .bin_i       (oper_q),
    .done_tick_o (conv_done),
    .bcd_o       (conv_bcd)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_bcd   = rsp_bcd_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed scenarios plus random traffic checked
// against a transaction-timeline model of the arbiter and decimal conversion.
module tb_bcd_conv_arbiter;

  localparam int LAT  = bcd_conv_arbiter_pkg::RSP_LATENCY;
  localparam int WDOG = 31;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [55:0] req_bin;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_bcd;
  logic        rsp_ovf;
  logic        rsp_err;
  logic        busy;

  bcd_conv_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_bin   (req_bin),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_bcd   (rsp_bcd),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int id;
    int bcd;
    bit ovf;
    bit err;
  } exp_rsp_t;

  int          n_err = 0;
  int          n_chk = 0;
  logic [3:0]  pend;
  int unsigned opnd [4];
  bit          hold;
  bit          wd_force;
  int          cyc;
  int          free_t;
  int          last_k;
  int          n_model_gnt;
  exp_rsp_t    rq [$];
  int          glog_id [$];
  int          glog_t [$];
  int          fair_exp [5] = '{0, 1, 2, 3, 0};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Decimal digits of the clamped operand, packed one digit per nibble.
  function automatic int to_bcd(input int unsigned v);
    int unsigned c;
    c = (v > 9999) ? 9999 : v;
    return int'(((c / 1000) << 12) | (((c / 100) % 10) << 8) | (((c / 10) % 10) << 4) | (c % 10));
  endfunction

  function automatic int unsigned pick_op();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 9999;
      2:       return 10000;
      3:       return 16383;
      default: return $urandom_range(0, 16383);
    endcase
  endfunction

  task automatic step();
    int       k;
    logic [3:0] eg;
    logic     eb;
    exp_rsp_t e;
    @(posedge clk);
    #1;
    req = pend;
    for (int i = 0; i < 4; i++) req_bin[i*14 +: 14] = 14'(opnd[i]);
    @(negedge clk);
    eg = '0;
    eb = (cyc < free_t);
    k  = -1;
    if (cyc >= free_t) begin
      for (int j = 4; j >= 1; j--) if (pend[(last_k + j) % 4]) k = (last_k + j) % 4;
    end
    if (k >= 0) begin
      eg     = 4'(1 << k);
      last_k = k;
      n_model_gnt++;
      e.id  = k;
      e.ovf = (opnd[k] > 9999);
      if (wd_force) begin
        e.due = cyc + WDOG + 3; e.bcd = 0; e.err = 1'b1; free_t = cyc + WDOG + 4;
      end else begin
        e.due = cyc + LAT; e.bcd = to_bcd(opnd[k]); e.err = 1'b0; free_t = cyc + LAT + 1;
      end
      rq.push_back(e);
      if (!hold) begin
        pend[k] = 1'b0;
        opnd[k] = $urandom_range(0, 16383);
      end
    end
    check_eq("gnt", 32'(gnt), 32'(eg));
    check_eq("busy", 32'(busy), 32'(eb));
    for (int i = 0; i < 4; i++) begin
      if (gnt[i] === 1'b1) begin
        glog_id.push_back(i);
        glog_t.push_back(cyc);
      end
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
      check_eq("rsp_bcd", 32'(rsp_bcd), 32'(e.bcd));
      check_eq("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
      check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
    end else begin
      check_eq("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end
    cyc++;
  endtask

  task automatic drain();
    for (int t = 0; t < 80 && (rq.size() != 0 || cyc < free_t); t++) step();
  endtask

  task automatic run_single(input int k, input int unsigned v);
    pend[k] = 1'b1;
    opnd[k] = v;
    step();
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check_eq({tag, "_rsp_bcd"}, 32'(rsp_bcd), 32'd0);
    check_eq({tag, "_rsp_ovf"}, 32'(rsp_ovf), 32'd0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Reset is held with all requests high: grants must stay off throughout.
  task automatic apply_reset(input string tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req   = 4'hF;
    @(negedge clk);
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req   = '0;
    rq.delete();
    pend   = '0;
    hold   = 1'b0;
    free_t = 0;
    last_k = 3;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_bin = '0; pend = '0; hold = 1'b0; wd_force = 1'b0;
    cyc = 0; free_t = 0; last_k = 3; n_model_gnt = 0;
    for (int i = 0; i < 4; i++) opnd[i] = 0;
    repeat (2) @(posedge clk);
    apply_reset("por");

    run_single(0, 1234);
    run_single(2, 16383);
    run_single(3, 0);

    // Fairness: all four held with operands 1..4 until five grants are issued.
    glog_id.delete(); glog_t.delete();
    hold = 1'b1; pend = 4'hF;
    for (int i = 0; i < 4; i++) opnd[i] = i + 1;
    n_model_gnt = 0;
    for (int t = 0; t < 200 && n_model_gnt < 5; t++) step();
    hold = 1'b0; pend = '0;
    drain();
    check_eq("fair_n", 32'(glog_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < glog_id.size(); i++) begin
      check_eq($sformatf("fair_id%0d", i), 32'(glog_id[i]), 32'(fair_exp[i]));
      if (i > 0) check_eq($sformatf("fair_gap%0d", i), 32'(glog_t[i] - glog_t[i-1]), 32'd18);
    end

    run_single(1, 9999);
    run_single(0, 10000);

    // Reset during the 9th cycle of a conversion abandons it silently.
    pend[1] = 1'b1; opnd[1] = 5678;
    step();
    repeat (7) step();
    apply_reset("mid");
    run_single(1, 5678);

    // Hide the converter's completion so the watchdog must end the transaction.
    wd_force = 1'b1;
    force dut.conv_done = 1'b0;
    run_single(2, 4321);
    release dut.conv_done;
    wd_force = 1'b0;
    run_single(3, 8765);

    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 12) begin
          pend[i] = 1'b1;
          opnd[i] = pick_op();
        end
      end
      step();
    end
    for (int t = 0; t < 200 && pend != 4'h0; t++) step();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
